// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the time-multiplexed FIR filter:
//   clog2      - ceiling log2 used to size indices and the accumulator
//   firState_t - FSM state encoding (IDLE, MAC, DONE)
//   saturate   - clamps a sign-extended accumulator value to an output width
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } firState_t;

    // Working width for saturation; any ACC_W up to this width is handled by
    // sign-extending the accumulator into it before the call.
    localparam int SAT_W = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Clamp a signed value (already sign-extended from ACC_W to SAT_W) to the
    // signed range of an outW-bit result. The caller truncates to outW bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      outW
    );
        logic signed [SAT_W-1:0] maxVal;
        logic signed [SAT_W-1:0] minVal;
        maxVal = $signed((SAT_W'(1) << (outW - 1)) - SAT_W'(1));
        minVal = ~maxVal;
        if (value > maxVal) begin
            return maxVal;
        end else if (value < minVal) begin
            return minVal;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_filter_param_coef.sv
// fir_coef_bank
// TAPS x COEF_W coefficient register file. One synchronous write port and a
// combinational read port addressed by the MAC tap index.
//   iClk_12MHz - clock
//   iRst       - asynchronous active-high reset, clears every coefficient
//   iWrEn      - write enable (already gated with "not busy" by the caller)
//   iWrAddr    - write index; indices >= TAPS are ignored
//   iWrData    - signed coefficient to store
//   iRdAddr    - read index (tap index)
//   oRdData    - coefficient at iRdAddr, 0 for out-of-range indices
module fir_coef_bank #(
    parameter int TAPS   = 16,
    parameter int COEF_W = 12,
    parameter int ADDR_W = 4
) (
    input  logic                     iClk_12MHz,
    input  logic                     iRst,
    input  logic                     iWrEn,
    input  logic [ADDR_W-1:0]        iWrAddr,
    input  logic signed [COEF_W-1:0] iWrData,
    input  logic [ADDR_W-1:0]        iRdAddr,
    output logic signed [COEF_W-1:0] oRdData
);

    logic signed [COEF_W-1:0] coefMem [TAPS];

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < TAPS; i++) begin
                coefMem[i] <= '0;
            end
        end else if (iWrEn && (int'(iWrAddr) < TAPS)) begin
            coefMem[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = (int'(iRdAddr) < TAPS) ? coefMem[iRdAddr] : '0;

endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param
// Time-multiplexed FIR filter: one shared multiplier walks all TAPS taps in
// the cycles between 600 kHz sample strobes.
//   iClk_12MHz       - sole clock, rising edge
//   iRst             - asynchronous active-high reset
//   iEnSample_600kHz - one-cycle sample strobe
//   iFirIn           - signed input sample, valid with the strobe
//   iCoefWr          - coefficient write enable (ignored while oBusy)
//   iCoefAddr        - coefficient index
//   iCoefData        - signed coefficient value
//   oFirOut          - saturated, scaled result, held between updates
//   oFirValid        - one-cycle pulse when oFirOut updates
//   oBusy            - high from strobe acceptance through the valid pulse
//   oOverrun         - sticky; a strobe arrived while a pass was running
//
// state | meaning
// IDLE  | waiting for a strobe; coefficient writes allowed once oBusy drops
// MAC   | one tap per cycle, acc += x[k]*c[k], k = 0..TAPS-1
// DONE  | scale, saturate and register the result, pulse oFirValid
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int  IN_W   = 3,
    parameter int  COEF_W = 12,
    parameter int  TAPS   = 16,
    parameter int  OUT_W  = 16,
    parameter int  SHIFT  = 0,
    localparam int ADDR_W = (clog2(TAPS) < 1) ? 1 : clog2(TAPS)
) (
    input  logic                     iClk_12MHz,
    input  logic                     iRst,
    input  logic                     iEnSample_600kHz,
    input  logic signed [IN_W-1:0]   iFirIn,
    input  logic                     iCoefWr,
    input  logic [ADDR_W-1:0]        iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    output logic signed [OUT_W-1:0]  oFirOut,
    output logic                     oFirValid,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = IN_W + COEF_W + clog2(TAPS);

    firState_t                 state;
    logic signed [IN_W-1:0]    xLine [TAPS];
    logic [ADDR_W-1:0]         tapIdx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [IN_W-1:0]    xTap;
    logic signed [COEF_W-1:0]  coefTap;
    logic signed [PROD_W-1:0]  product;

    fir_coef_bank #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) uCoefBank (
        .iClk_12MHz (iClk_12MHz),
        .iRst       (iRst),
        .iWrEn      (iCoefWr && !oBusy),
        .iWrAddr    (iCoefAddr),
        .iWrData    (iCoefData),
        .iRdAddr    (tapIdx),
        .oRdData    (coefTap)
    );

    // Tap 0 is first read in the cycle after the strobe, so a coefficient
    // written on the strobe edge is already visible to this pass.
    assign xTap    = xLine[tapIdx];
    assign product = PROD_W'(xTap) * PROD_W'(coefTap);

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            tapIdx    <= '0;
            acc       <= '0;
            oFirOut   <= '0;
            oFirValid <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                xLine[k] <= '0;
            end
        end else begin
            oFirValid <= 1'b0;

            // Busy covers the valid cycle too; a strobe accepted in that
            // same cycle re-asserts it below.
            if (oFirValid) begin
                oBusy <= 1'b0;
            end

            if (iEnSample_600kHz && (state != IDLE)) begin
                oOverrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (iEnSample_600kHz) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            xLine[k] <= xLine[k-1];
                        end
                        xLine[0] <= iFirIn;
                        tapIdx   <= '0;
                        acc      <= '0;
                        oBusy    <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc    <= acc + ACC_W'(product);
                    tapIdx <= tapIdx + ADDR_W'(1);
                    if (tapIdx == ADDR_W'(TAPS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    oFirOut   <= OUT_W'(saturate(SAT_W'(acc >>> SHIFT), OUT_W));
                    oFirValid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb_fir_filter_param
// Drives a default-width filter and an OUT_W=8 filter with the same stimulus
// and compares both against a plain-arithmetic model of the convolution.
module tb_fir_filter_param;

    localparam int TAPS = 16;

    logic        iClk_12MHz = 1'b0;
    logic        iRst = 1'b1;
    logic        iEnSample_600kHz = 1'b0;
    logic [2:0]  iFirIn = '0;
    logic        iCoefWr = 1'b0;
    logic [3:0]  iCoefAddr = '0;
    logic [11:0] iCoefData = '0;

    logic [15:0] oFirOut;
    logic        oFirValid, oBusy, oOverrun;
    logic [7:0]  satOut;
    logic        satValid, satBusy, satOverrun;

    int xs [TAPS];
    int cs [TAPS];
    bit overrunExp;
    int vectors = 0;
    int miscompares = 0;

    always #41 iClk_12MHz = ~iClk_12MHz;

    fir_filter_param dut (
        .iClk_12MHz       (iClk_12MHz),
        .iRst             (iRst),
        .iEnSample_600kHz (iEnSample_600kHz),
        .iFirIn           (iFirIn),
        .iCoefWr          (iCoefWr),
        .iCoefAddr        (iCoefAddr),
        .iCoefData        (iCoefData),
        .oFirOut          (oFirOut),
        .oFirValid        (oFirValid),
        .oBusy            (oBusy),
        .oOverrun         (oOverrun)
    );

    fir_filter_param #(.OUT_W(8)) dutSat (
        .iClk_12MHz       (iClk_12MHz),
        .iRst             (iRst),
        .iEnSample_600kHz (iEnSample_600kHz),
        .iFirIn           (iFirIn),
        .iCoefWr          (iCoefWr),
        .iCoefAddr        (iCoefAddr),
        .iCoefData        (iCoefData),
        .oFirOut          (satOut),
        .oFirValid        (satValid),
        .oBusy            (satBusy),
        .oOverrun         (satOverrun)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int satTo(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int modelSum();
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += xs[k] * cs[k];
        return s;
    endfunction

    task automatic clearModel();
        for (int k = 0; k < TAPS; k++) begin
            xs[k] = 0;
            cs[k] = 0;
        end
        overrunExp = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        check({tag, "_out"},     oFirOut, 16'h0000);
        check({tag, "_valid"},   {15'b0, oFirValid}, 16'h0000);
        check({tag, "_busy"},    {15'b0, oBusy}, 16'h0000);
        check({tag, "_overrun"}, {15'b0, oOverrun}, 16'h0000);
        check({tag, "_satout"},  {8'h00, satOut}, 16'h0000);
    endtask

    task automatic doReset();
        iRst = 1'b1;
        repeat (2) @(posedge iClk_12MHz);
        #1;
        iRst = 1'b0;
        clearModel();
    endtask

    task automatic writeCoef(input logic [3:0] a, input logic [11:0] d);
        iCoefWr = 1'b1;
        iCoefAddr = a;
        iCoefData = d;
        @(posedge iClk_12MHz);
        #1;
        iCoefWr = 1'b0;
        cs[a] = int'($signed(d));
    endtask

    // One 20-cycle sample period: strobe (optionally with a coefficient write
    // on the same edge), optional extra strobe and busy-time write, then
    // checks on latency, pulse count, results of both widths and status.
    task automatic runPass(input logic [2:0] s, input bit wr, input logic [3:0] wa,
                           input logic [11:0] wd, input int extraAt, input int busyWrAt);
        int pulses;
        int lat;
        int expSum;
        logic [15:0] got;
        logic [7:0] gotSat;
        pulses = 0;
        lat = -1;
        got = 16'h0;
        gotSat = 8'h0;
        iEnSample_600kHz = 1'b1;
        iFirIn = s;
        iCoefWr = wr;
        iCoefAddr = wa;
        iCoefData = wd;
        @(posedge iClk_12MHz);
        #1;
        iEnSample_600kHz = 1'b0;
        iCoefWr = 1'b0;
        if (wr) cs[wa] = int'($signed(wd));
        for (int k = TAPS - 1; k > 0; k--) xs[k] = xs[k-1];
        xs[0] = int'($signed(s));
        expSum = modelSum();
        check("busy_rise", {15'b0, oBusy}, 16'h0001);
        for (int e = 1; e < 20; e++) begin
            if (e == extraAt) begin
                iEnSample_600kHz = 1'b1;
                iFirIn = 3'($urandom);
                overrunExp = 1'b1;
            end
            if (e == busyWrAt) begin
                iCoefWr = 1'b1;
                iCoefAddr = 4'($urandom);
                iCoefData = 12'($urandom);
            end
            @(posedge iClk_12MHz);
            #1;
            iEnSample_600kHz = 1'b0;
            iCoefWr = 1'b0;
            if (oFirValid) begin
                pulses++;
                lat = e;
                got = oFirOut;
            end
            if (satValid) gotSat = satOut;
            if (e == TAPS + 1) check("busy_in_valid", {14'b0, oBusy, satBusy}, 16'h0003);
            if (e == TAPS + 2) check("busy_fall", {14'b0, oBusy, satBusy}, 16'h0000);
        end
        check("valid_count", 16'(pulses), 16'd1);
        check("latency", 16'(lat), 16'(TAPS + 1));
        check("out16", got, 16'(satTo(expSum, 16)));
        check("out8", {8'h00, gotSat}, {8'h00, 8'(satTo(expSum, 8))});
        check("out_held", oFirOut, 16'(satTo(expSum, 16)));
        check("overrun", {14'b0, oOverrun, satOverrun}, overrunExp ? 16'h0003 : 16'h0000);
    endtask

    task automatic resetMidPass(input logic [2:0] s);
        int pulses;
        pulses = 0;
        iEnSample_600kHz = 1'b1;
        iFirIn = s;
        @(posedge iClk_12MHz);
        #1;
        iEnSample_600kHz = 1'b0;
        repeat (7) @(posedge iClk_12MHz);
        #1;
        iRst = 1'b1;
        @(posedge iClk_12MHz);
        #1;
        iRst = 1'b0;
        clearModel();
        for (int e = 0; e < 20; e++) begin
            @(posedge iClk_12MHz);
            #1;
            if (oFirValid || satValid) pulses++;
        end
        check("midreset_pulses", 16'(pulses), 16'd0);
        checkIdleZero("midreset");
    endtask

    initial begin
        clearModel();
        iRst = 1'b1;
        repeat (3) @(posedge iClk_12MHz);
        #1;
        checkIdleZero("in_reset");
        iRst = 1'b0;
        @(posedge iClk_12MHz);
        #1;
        checkIdleZero("after_reset");

        // zero coefficients give zero output
        runPass(3'b011, 1'b0, 4'd0, 12'd0, 0, 0);

        // positive impulse through c[k] = k+1
        doReset();
        for (int k = 0; k < TAPS; k++) writeCoef(4'(k), 12'(k + 1));
        runPass(3'b011, 1'b0, 4'd0, 12'd0, 0, 0);
        repeat (TAPS) runPass(3'b000, 1'b0, 4'd0, 12'd0, 0, 0);

        // negative impulse
        runPass(3'b111, 1'b0, 4'd0, 12'd0, 0, 0);
        repeat (TAPS) runPass(3'b000, 1'b0, 4'd0, 12'd0, 0, 0);

        // saturation at both output widths
        for (int k = 0; k < TAPS; k++) writeCoef(4'(k), 12'd2047);
        repeat (TAPS + 1) runPass(3'b011, 1'b0, 4'd0, 12'd0, 0, 0);
        repeat (TAPS + 1) runPass(3'b100, 1'b0, 4'd0, 12'd0, 0, 0);

        // overrun: second strobe five edges in is dropped
        runPass(3'($urandom), 1'b0, 4'd0, 12'd0, 5, 0);
        runPass(3'($urandom), 1'b0, 4'd0, 12'd0, 0, 0);
        runPass(3'($urandom), 1'b0, 4'd0, 12'd0, 17, 0);

        // random coefficients and samples, with same-edge and busy-time writes
        for (int k = 0; k < TAPS; k++) writeCoef(4'(k), 12'($urandom));
        for (int n = 0; n < 30; n++) begin
            runPass(3'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom), 12'($urandom),
                    0, ($urandom_range(0, 2) == 0) ? 3 : 0);
        end

        // reset in the middle of a pass
        resetMidPass(3'b011);
        runPass(3'b001, 1'b0, 4'd0, 12'd0, 0, 0);
        runPass(3'b101, 1'b0, 4'd0, 12'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_filter_param.md
# fir_filter_param

Parametrised, time-multiplexed FIR filter for the 12 MHz / 600 kHz sample datapath. It generalises the fixed 3-bit-in / 16-bit-out FIR with several additions: configurable input, coefficient and output widths; a configurable tap count; run-time coefficient loading; output scaling with saturation; and valid/busy/overrun status. It sits between the sample-strobe generator and downstream decimation/logging. A single MAC is shared across all taps within one sample period.

## Interface
- IN_W, 3: signed input sample width.
- COEF_W, 12: signed coefficient width.
- TAPS, 16: number of taps; must satisfy TAPS+2 ≤ clock cycles per sample strobe (20 at 12 MHz/600 kHz).
- OUT_W, 16: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- iClk_12MHz  in  1  sole clock; all logic on its rising edge.
- iRst  in  1  reset, asynchronous and active-high.
- iEnSample_600kHz  in  1  sample strobe, one clock wide.
- iFirIn  in  IN_W  signed two's-complement sample, valid with the strobe.
- iCoefWr  in  1  coefficient write enable.
- iCoefAddr  in  clog2(TAPS)  coefficient index.
- iCoefData  in  COEF_W  signed coefficient value.
- oFirOut  out  OUT_W  signed filtered result, held between updates.
- oFirValid  out  1  one-cycle pulse when oFirOut updates.
- oBusy  out  1  high while a MAC pass is in progress.
- oOverrun  out  1  sticky; set when a strobe arrives while busy.

## Operation
- Reset (iRst=1, asynchronous):
  - state→IDLE; delay line, coefficient bank, accumulator, oFirOut, oFirValid, oBusy and oOverrun all cleared to 0.
- IDLE, strobe=1:
  - Shift iFirIn into delay line position x[0]; x[k]→x[k+1]; x[TAPS-1] is discarded.
  - Clear tap index and accumulator; go to MAC.
- MAC (TAPS cycles): on cycle k, acc += x[k]*c[k]. Then go to DONE.
- DONE (1 cycle):
  - oFirOut ← sat(acc >>> SHIFT, OUT_W); oFirValid=1.
  - Go to IDLE.
- Arithmetic widths:
  - Product width is IN_W+COEF_W.
  - Accumulator width is ACC_W = IN_W+COEF_W+clog2(TAPS); the accumulator never wraps.
- Saturation: results above 2^(OUT_W-1)-1 clamp to that value; results below −2^(OUT_W-1) clamp to that value.
- Strobe while oBusy=1 (MAC or DONE):
  - The sample is dropped and the delay line is unchanged.
  - oOverrun←1; it stays set until reset.
- Coefficient writes:
  - Accepted only when oBusy=0: c[iCoefAddr] ← iCoefData at that edge.
  - Writes while busy are ignored.
  - An address ≥ TAPS is ignored.
- Strobe and coefficient write in the same IDLE cycle: the write takes effect and is used by that same pass. Tap 0 is read no earlier than the first MAC cycle.
- Reset mid-pass: the pass is abandoned and no oFirValid pulse is produced.

## Timing
- Strobe sampled high at edge T:
  - oBusy=1 from T through T+TAPS+1.
  - oFirValid=1 for one cycle after edge T+TAPS+1, i.e. latency TAPS+1 edges (17 at defaults).
- oBusy falls in the same edge that oFirValid falls. A new strobe at edge T+TAPS+2 or later is accepted.
- oFirOut changes only on the oFirValid edge.
- The tap loop must not be combinationally unrolled: one multiply per cycle, with the product registered into the accumulator.

## Structure
- The shared package fir_pkg holds:
  - a clog2 function;
  - the state encoding (IDLE=2'd0, MAC=2'd1, DONE=2'd2);
  - a saturate function parametrised on ACC_W and OUT_W.
- Sub-module fir_coef_bank: TAPS×COEF_W register file with write port and combinational read by tap index, cleared on iRst.
- The top level holds the delay line, FSM, MAC and output register.

## Test plan
All scenarios use default parameters unless stated.

1. **Reset check.** Hold iRst, then release with zero coefficients; strobe 3'b011 → oFirValid 17 edges later with oFirOut=16'h0000, oOverrun=0.
2. **Positive impulse.**
   - Load c[k]=k+1. Strobe 3'b011 once, then 3'b000 every 20 cycles.
   - Expect successive outputs 3, 6, 9 … 48, then 0.
   - Exactly one oFirValid per strobe.
3. **Negative impulse.**
   - Same coefficients; first sample 3'b111 (−1).
   - Expect 16'hFFFF, 16'hFFFE … 16'hFFF0 (−16), then 0.
4. **Saturation.**
   - Instance with OUT_W=8; all coefficients 2047; constant input 3'b011 → settles at 8'h7F.
   - Constant input 3'b100 → settles at 8'h80.
5. **Overrun.**
   - Strobe at edge T and again at T+5 → only one oFirValid (at T+17); oOverrun=1 and stays set.
   - The next strobe at T+20 gives output consistent with only one sample having been shifted.
6. **Reset mid-pass.**
   - Assert iRst at T+8 for 1 cycle → no oFirValid, oFirOut=0, coefficients read back as 0.
   - A subsequent impulse yields 0.
